wbs_uart_tx: RTL and testbench
==============================

Name: wbs_uart_tx

Overview:
- Wishbone B4 pipelined peripheral for serial transmit; one slot on the wbx_1master peripheral side.
- Downstream consumer of whatever wbm_* controller drives the crossbar, e.g. wbm_spi forwarding host bytes.
- Written bytes are buffered in a FIFO and serialised 8N1, LSB first, on uart_tx.
- Baud timing comes from TICKS_PER_BAUD; no fractional divider.

Parameters:
- TICKS_PER_BAUD, 4: wb_clk_i cycles per UART bit; legal range >= 2.
- FIFO_AW, 4: FIFO address width; depth is 2**FIFO_AW (16 entries).

Ports:
- wb_clk_i  in  1  system clock; all logic is posedge.
- wb_rst_i  in  1  reset; asynchronous assert, active-low (0 = reset). Deassertion is synchronised externally.
- wb_cyc_i  in  1  cycle select for this peripheral.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  4  word address.
- wb_sel_i  in  4  byte lanes.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_stall_o  out  1  request not accepted this cycle.
- wb_ack_o  out  1  one-cycle completion pulse.
- uart_tx  out  1  serial line; idles high.

Behaviour:
- Reset (wb_rst_i=0):
  - wb_ack_o=0, wb_dat_o=0, uart_tx=1.
  - FIFO emptied; state IDLE; tick counter and bit counter cleared.
  - Applies immediately, including mid-frame: the line returns high and no partial frame resumes afterwards.
- Request acceptance:
  - A request is accepted when wb_cyc_i & wb_stb_i & !wb_stall_o.
  - wb_ack_o is asserted exactly 1 cycle after acceptance; one ack per request.
  - Back-to-back requests are allowed, giving one ack per cycle.
  - If wb_cyc_i drops, pending acks are discarded.
- Register map (wb_adr_i):
  - 0 DATA write: if wb_sel_i[0]=1, push wb_dat_i[7:0] into the FIFO. If wb_sel_i[0]=0, the write is acked with no push.
  - 0 DATA read: returns 0.
  - 1 STATUS read:
    - bit0 = full.
    - bit1 = empty.
    - bit2 = busy (state != IDLE).
    - bits[FIFO_AW+8:8] = FIFO level (0..2**FIFO_AW).
    - All other bits 0.
  - 1 STATUS write: ignored, still acked.
  - Other addresses: reads return 0, writes are ignored; both are acked.
  - wb_dat_o is registered and valid in the same cycle as wb_ack_o. Otherwise it holds 0.
- Stall:
  - wb_stall_o = wb_cyc_i & wb_stb_i & wb_we_i & (wb_adr_i==0) & full. It is combinational from the current full flag.
  - A push is never dropped; the write is held off until space frees.
  - A pop in the same cycle does not clear stall in that cycle. The write is accepted on the following cycle.
- FIFO:
  - Read and write pointers are FIFO_AW+1 bits and wrap modulo 2**(FIFO_AW+1).
  - full = (MSBs differ & low bits equal); empty = pointers equal.
  - Level = wptr - rptr, computed modulo.
  - Simultaneous push and pop when non-empty leaves level unchanged.
- Transmitter FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if !empty, pop the head into the shift register and go to START on the next edge. uart_tx=1.
  - START: uart_tx=0 for TICKS_PER_BAUD cycles.
  - DATA: 8 bits, LSB first, each held TICKS_PER_BAUD cycles. The bit counter is 3 bits.
  - STOP: uart_tx=1 for TICKS_PER_BAUD cycles, then IDLE.
  - From STOP, if the FIFO is non-empty, the next frame's START begins after exactly 1 IDLE cycle.
  - Frame length is 10*TICKS_PER_BAUD cycles plus 1 IDLE gap between consecutive frames.
- uart_tx is registered; no glitches.
- Write-to-line latency: a write accepted into an empty FIFO while IDLE drives the start bit 2 cycles after acceptance (cycle 1 push, cycle 2 pop and load, start bit from cycle 3).

Optional Feature:
- Macro: WBS_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It transmits the even parity bit (XOR of the 8 data bits) for TICKS_PER_BAUD cycles.
  - Frame length is 11*TICKS_PER_BAUD.
  - STATUS bit3 reads 1.
- Undefined:
  - No PARITY state; 8N1 with a 10-bit frame.
  - STATUS bit3 reads 0.

Test Plan:
- Reset then idle: hold wb_rst_i=0 for 3 cycles, release.
  - Required: uart_tx=1, wb_ack_o=0.
  - STATUS read returns 0x00000002 (empty).
- Single byte, TICKS_PER_BAUD=4: write 0xA5 to adr 0.
  - Required: ack 1 cycle later; uart_tx low 4 cycles starting 2 cycles after acceptance.
  - Then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high.
  - Total 40 cycles; busy=1 throughout.
- Fill to full: write 17 bytes back-to-back without draining, with the first byte already popped.
  - Required: STATUS level reaches 16 and full=1.
  - The 18th write sees wb_stall_o=1 until the first STOP completes and a pop occurs.
  - Accepted one cycle after the pop; no byte lost; the line order matches the write order.
- Byte-lane and decode: write 0x12 with wb_sel_i=4'b1110, then write to adr 7.
  - Required: both acked; FIFO level stays 0; uart_tx stays 1.
- Reset mid-frame: assert wb_rst_i=0 during DATA bit 3.
  - Required: uart_tx=1 within the same cycle (asynchronous); STATUS after release = 0x00000002.
  - No remaining frame is sent.
- Parity build (WBS_UART_TX_PARITY_EN): write 0x07.
  - Required: parity bit 1 after the data bits; frame length 44 cycles; STATUS bit3=1.

Source files
------------

// File: rtl/wbs_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : wbs_uart_tx_if
// Purpose  : Wishbone B4 pipelined bus bundle for the wbs_uart_tx peripheral.
// Signals  : wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[3:0], wb_sel_i[3:0],
//            wb_dat_i[31:0]     master -> slave
//            wb_dat_o[31:0], wb_stall_o, wb_ack_o      slave -> master
// Modports : master (bus controller side), slave (peripheral side)
// Revision : 1.0 - initial release
// ============================================================================
interface wbs_uart_tx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_stall_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_stall_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_stall_o, wb_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/wbs_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : wbs_uart_tx
// Purpose  : Wishbone B4 pipelined UART transmitter. Bytes written to DATA
//            are queued in a FIFO and sent 8N1, LSB first, on uart_tx.
// Ports    : wb_clk_i  - system clock (posedge)
//            wb_rst_i  - asynchronous reset, active low
//            wb        - Wishbone slave bundle (wbs_uart_tx_if.slave)
//            uart_tx   - serial output, idles high
// Map      : 0 DATA   (W: push dat[7:0] if sel[0]; R: 0)
//            1 STATUS (R: bit0 full, bit1 empty, bit2 busy, bit3 parity
//                      enabled, bits[FIFO_AW+8:8] level)
// Option   : WBS_UART_TX_PARITY_EN adds an even parity bit before STOP.
// Revision : 1.0 - initial release
// ============================================================================
module wbs_uart_tx #(
  parameter int TICKS_PER_BAUD = 4,
  parameter int FIFO_AW        = 4
) (
  input  wire logic        wb_clk_i,
  input  wire logic        wb_rst_i,
  wbs_uart_tx_if.slave     wb,
  output logic             uart_tx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TICKS_PER_BAUD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BAUD - 1);
`ifdef WBS_UART_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wptr_q, wptr_d;
  logic [FIFO_AW:0] rptr_q, rptr_d;

  state_t           state_q;
  logic [TW-1:0]    tick_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             ack_q;
  logic [31:0]      dat_q;
`ifdef WBS_UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic             w_full, w_empty, w_stall, w_accept, w_push, w_pop;
  logic [FIFO_AW:0] w_level;
  logic [7:0]       w_head;
  logic [31:0]      w_status, w_rdata;
  logic             w_unused_ok;

  assign w_full   = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                    (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign w_empty  = (wptr_q == rptr_q);
  assign w_level  = wptr_q - rptr_q;
  assign w_head   = mem_q[rptr_q[FIFO_AW-1:0]];

  // Stall only on DATA writes while full; reads and other writes always pass.
  assign w_stall  = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i &
                    (wb.wb_adr_i == 4'd0) & w_full;
  assign w_accept = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall;
  assign w_push   = w_accept & wb.wb_we_i & (wb.wb_adr_i == 4'd0) & wb.wb_sel_i[0];
  assign w_pop    = (state_q == S_IDLE) & ~w_empty;

  assign wptr_d   = wptr_q + (FIFO_AW+1)'(w_push);
  assign rptr_d   = rptr_q + (FIFO_AW+1)'(w_pop);

  always_comb begin
    w_status                = 32'd0;
    w_status[0]             = w_full;
    w_status[1]             = w_empty;
    w_status[2]             = (state_q != S_IDLE);
    w_status[3]             = PARITY_FLAG;
    w_status[FIFO_AW+8:8]   = w_level;
  end

  assign w_rdata     = (wb.wb_adr_i == 4'd1) ? w_status : 32'd0;
  assign w_unused_ok = &{1'b0, wb.wb_dat_i[31:8], wb.wb_sel_i[3:1]};

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= wb.wb_dat_i[7:0];
    end
  end

  // Bus response and FIFO pointers
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_q  <= 1'b0;
      dat_q  <= 32'd0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      ack_q  <= w_accept;
      dat_q  <= (w_accept && !wb.wb_we_i) ? w_rdata : 32'd0;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Transmitter: the line level for each state is loaded on the transition
  // into it, so uart_tx comes straight from a flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
`ifdef WBS_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          tick_q <= '0;
          bit_q  <= 3'd0;
          if (w_pop) begin
            shift_q <= w_head;
`ifdef WBS_UART_TX_PARITY_EN
            par_q   <= ^w_head;
`endif
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef WBS_UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            tick_q <= tick_q + TW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          tick_q  <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // A pending ack is dropped if the master abandons the cycle.
  assign wb.wb_ack_o   = ack_q & wb.wb_cyc_i;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = w_stall;
  assign uart_tx       = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_wbs_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_wbs_uart_tx
// Purpose  : Self-checking bench for wbs_uart_tx (TICKS_PER_BAUD=4,
//            FIFO_AW=4). Build with WBS_UART_TX_PARITY_EN for the parity
//            variant; expected frame length and STATUS bit3 follow it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wbs_uart_tx;

  localparam int T = 4;
`ifdef WBS_UART_TX_PARITY_EN
  localparam int          NB    = 11;
  localparam logic [31:0] PFLAG = 32'h8;
`else
  localparam int          NB    = 10;
  localparam logic [31:0] PFLAG = 32'h0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic uart_tx;
  always #5 clk = ~clk;

  wbs_uart_tx_if bus();

  wbs_uart_tx #(.TICKS_PER_BAUD(T), .FIFO_AW(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .wb       (bus),
    .uart_tx  (uart_tx)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;
  logic mon_en = 1'b0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (NB == 11 && idx == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(8'h31 + i * 13);
  endfunction

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 4'd0; bus.wb_sel_i = 4'd0; bus.wb_dat_i = 32'd0;
  endtask

  task automatic bus_drive(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_sel_i = sel;  bus.wb_dat_i = dat;
  endtask

  // Single request: ack + data next cycle, then ack must fall.
  task automatic wb_op(input logic we, input logic [3:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [31:0] exp_dat, input string name);
    int guard;
    @(negedge clk);
    bus_drive(we, adr, sel, dat);
    #1;
    guard = 0;
    while (bus.wb_stall_o && guard < 200) begin
      @(negedge clk); #1; guard++;
    end
    check({name, "_stall"}, 32'(bus.wb_stall_o), 32'd0);
    @(negedge clk);
    check({name, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
    check({name, "_dat"}, bus.wb_dat_o, exp_dat);
    bus_idle();
    @(negedge clk);
    check({name, "_ack_once"}, 32'(bus.wb_ack_o), 32'd0);
  endtask

  // Write one byte into an idle, empty transmitter, then poll STATUS every
  // cycle while checking every line cycle of the frame.
  task automatic send_and_check(input logic [7:0] d, input string name);
    @(negedge clk);
    bus_drive(1'b1, 4'd0, 4'b0001, {24'd0, d});
    #1;
    check({name, "_stall"}, 32'(bus.wb_stall_o), 32'd0);
    @(negedge clk);
    check({name, "_wack"}, 32'(bus.wb_ack_o), 32'd1);
    check({name, "_tx_pre"}, 32'(uart_tx), 32'd1);
    bus_drive(1'b0, 4'd1, 4'hF, 32'd0);
    for (int c = 0; c <= NB * T; c++) begin
      @(negedge clk);
      if (c < NB * T) check($sformatf("%s_tx_c%0d", name, c), 32'(uart_tx), 32'(exp_bit(d, c / T)));
      check($sformatf("%s_rack_c%0d", name, c), 32'(bus.wb_ack_o), 32'd1);
      if (c >= 1) check($sformatf("%s_busy_c%0d", name, c), 32'(bus.wb_dat_o[2]), 32'd1);
    end
    bus_idle();
    wb_op(1'b0, 4'd1, 4'hF, 32'd0, 32'h2 | PFLAG, {name, "_idle_status"});
    check({name, "_tx_after"}, 32'(uart_tx), 32'd1);
  endtask

  // Line monitor: samples each bit in the middle of its slot.
  initial begin : monitor
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !uart_tx) begin
        repeat (T / 2) @(negedge clk);
        check("mon_start", 32'(uart_tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (T) @(negedge clk);
          b[k] = uart_tx;
        end
        if (NB == 11) begin
          repeat (T) @(negedge clk);
          check("mon_parity", 32'(uart_tx), 32'(^b));
        end
        repeat (T) @(negedge clk);
        check("mon_stop", 32'(uart_tx), 32'd1);
        rx_q.push_back(b);
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        we;
    logic [3:0]  adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  initial begin : stim
    vec_t vecs[9];
    int   t0, guard, low_cnt;

    vecs[0] = '{1'b0, 4'd1, 4'hF, 32'd0,        32'h2 | PFLAG};
    vecs[1] = '{1'b0, 4'd0, 4'hF, 32'd0,        32'h0};
    vecs[2] = '{1'b1, 4'd0, 4'hE, 32'h12,       32'h0};
    vecs[3] = '{1'b0, 4'd1, 4'hF, 32'd0,        32'h2 | PFLAG};
    vecs[4] = '{1'b1, 4'd7, 4'hF, 32'hFF,       32'h0};
    vecs[5] = '{1'b0, 4'd1, 4'hF, 32'd0,        32'h2 | PFLAG};
    vecs[6] = '{1'b1, 4'd1, 4'hF, 32'hFFFFFFFF, 32'h0};
    vecs[7] = '{1'b0, 4'd1, 4'hF, 32'd0,        32'h2 | PFLAG};
    vecs[8] = '{1'b0, 4'd7, 4'hF, 32'd0,        32'h0};

    // Reset then idle
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", 32'(uart_tx), 32'd1);
    check("post_rst_ack", 32'(bus.wb_ack_o), 32'd0);

    // Register map, byte lanes and decode
    for (int i = 0; i < 9; i++) begin
      wb_op(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, vecs[i].exp,
            $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tx", i), 32'(uart_tx), 32'd1);
    end

    // Single frames (0x07 has odd popcount: parity bit 1)
    send_and_check(8'hA5, "a5");
    send_and_check(8'h07, "b07");

    // Fill to full while the first byte is on the line
    rx_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    t0 = cyc_cnt;
    for (int i = 0; i < 17; i++) begin
      bus_drive(1'b1, 4'd0, 4'b0001, {24'd0, fill_byte(i)});
      #1;
      check($sformatf("fill%0d_stall", i), 32'(bus.wb_stall_o), 32'd0);
      @(negedge clk);
      check($sformatf("fill%0d_ack", i), 32'(bus.wb_ack_o), 32'd1);
    end
    bus_idle();
    wb_op(1'b0, 4'd1, 4'hF, 32'd0, 32'h1005 | PFLAG, "full_status");
    bus_drive(1'b1, 4'd0, 4'b0001, {24'd0, fill_byte(17)});
    #1;
    check("w18_stall_seen", 32'(bus.wb_stall_o), 32'd1);
    guard = 0;
    while (bus.wb_stall_o && guard < 300) begin
      @(negedge clk); #1; guard++;
    end
    check("w18_stall_release_cycle", 32'(cyc_cnt - t0), 32'(3 + NB * T));
    @(negedge clk);
    check("w18_ack", 32'(bus.wb_ack_o), 32'd1);
    bus_idle();
    guard = 0;
    while (rx_q.size() < 18 && guard < 18 * (NB * T + 1) + 200) begin
      @(negedge clk); guard++;
    end
    check("fill_rx_count", 32'(rx_q.size()), 32'd18);
    for (int i = 0; i < 18 && i < rx_q.size(); i++)
      check($sformatf("fill_rx%0d", i), 32'(rx_q[i]), 32'(fill_byte(i)));
    repeat (2 * T) @(negedge clk);
    mon_en = 1'b0;
    wb_op(1'b0, 4'd1, 4'hF, 32'd0, 32'h2 | PFLAG, "drained_status");

    // Reset during data bit 3 of 0x35 (bit3 = 0, so a high line proves reset)
    wb_op(1'b1, 4'd0, 4'b0001, 32'h35, 32'h0, "mf_write");
    check("mf_start", 32'(uart_tx), 32'd0);
    repeat (17) @(negedge clk);
    check("mf_bit3_pre", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mf_async_tx", 32'(uart_tx), 32'd1);
    check("mf_async_ack", 32'(bus.wb_ack_o), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    low_cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (!uart_tx) low_cnt++;
    end
    check("mf_no_resume", 32'(low_cnt), 32'd0);
    wb_op(1'b0, 4'd1, 4'hF, 32'd0, 32'h2 | PFLAG, "mf_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
